// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, ALU operand/result bus and completion report
// between alu_issue_ctrl and its surroundings.
interface alu_issue_ctrl_if #(
  parameter int N  = 32,
  parameter int AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [3+3*AW-1:0] in_instr;
  logic [N-1:0]      alu_a;
  logic [N-1:0]      alu_b;
  logic [2:0]        alu_op;
  logic [N-1:0]      alu_c;
  logic              alu_ov;
  logic              done;
  logic [AW-1:0]     done_rd;
  logic              done_ov;

  modport master (
    input  in_valid, in_instr, alu_c, alu_ov,
    output in_ready, alu_a, alu_b, alu_op,
    output done, done_rd, done_ov
  );

  modport slave (
    output in_valid, in_instr, alu_c, alu_ov,
    input  in_ready, alu_a, alu_b, alu_op,
    input  done, done_rd, done_ov
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: regfile, IDLE/ISSUE/CAPTURE/WB sequencer.
// Optional OV_TRAP_EN: suppress overflowed writeback, sticky trap out.
module alu_issue_ctrl #(
  parameter int N    = 32,
  parameter int REGS = 8,
  parameter int AW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.master bus,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [N-1:0]     ld_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [N-1:0]     dbg_data
`ifdef OV_TRAP_EN
  ,
  output logic             trap
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WB
  } state_t;

  state_t        state;
  state_t        nstate;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [N-1:0]  c_q;
  logic          ov_q;
  logic          qual_ov;
  logic          wr_en;
  logic          accept;
  logic [N-1:0]  rf [REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (bus.in_valid) nstate = ISSUE;
      ISSUE:   nstate = CAPTURE;
      CAPTURE: nstate = WB;
      WB:      nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && bus.in_valid;

  // ADD (000) and SUB (100) are the only ops whose overflow counts
  assign qual_ov = ov_q && (op_q[1:0] == 2'b00);

`ifdef OV_TRAP_EN
  assign wr_en = (state == WB) && !qual_ov;
`else
  assign wr_en = (state == WB);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (accept) begin
      {op_q, rd_q, rs1_q, rs2_q} <= bus.in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= 3'b000;
    end else if (state == ISSUE) begin
      bus.alu_a  <= rf[rs1_q];
      bus.alu_b  <= rf[rs2_q];
      bus.alu_op <= op_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q  <= '0;
      ov_q <= 1'b0;
    end else if (state == CAPTURE) begin
      c_q  <= bus.alu_c;
      ov_q <= bus.alu_ov;
    end
  end

  // Preload only in IDLE, writeback only in WB: the two never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
    end else if ((state == IDLE) && ld_en) begin
      rf[ld_addr] <= ld_data;
    end else if (wr_en) begin
      rf[rd_q] <= c_q;
    end
  end

`ifdef OV_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          trap <= 1'b0;
    else if ((state == WB) && qual_ov) trap <= 1'b1;
  end
`endif

  assign bus.in_ready = (state == IDLE);
  assign bus.done     = (state == WB);
  assign bus.done_rd  = rd_q;
  assign bus.done_ov  = (state == WB) && qual_ov;
  assign dbg_data     = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed cases then random instructions
// against a regfile reference model and a behavioural ALU.
module tb_alu_issue_ctrl;
  localparam int N    = 32;
  localparam int AW   = 3;
  localparam int REGS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [N-1:0]  ld_data;
  logic [AW-1:0] dbg_addr;
  logic [N-1:0]  dbg_data;
  bit            force_ov;
  int            vectors     = 0;
  int            miscompares = 0;
  logic [N-1:0]  mdl [REGS];
`ifdef OV_TRAP_EN
  logic          trap;
  bit            trap_exp;
`endif

  alu_issue_ctrl_if #(.N(N), .AW(AW)) bus ();

  alu_issue_ctrl #(.N(N), .REGS(REGS), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`ifdef OV_TRAP_EN
    ,
    .trap     (trap)
`endif
  );

  always #5 clk = ~clk;

  // external combinational ALU; force_ov makes logical ops raise OV
  always_comb begin
    bus.alu_c  = '0;
    bus.alu_ov = 1'b0;
    case (bus.alu_op[1:0])
      2'b00: begin
        if (bus.alu_op[2]) begin
          bus.alu_c  = bus.alu_a - bus.alu_b;
          bus.alu_ov = (bus.alu_a[N-1] != bus.alu_b[N-1]) &&
                       (bus.alu_c[N-1] != bus.alu_a[N-1]);
        end else begin
          bus.alu_c  = bus.alu_a + bus.alu_b;
          bus.alu_ov = (bus.alu_a[N-1] == bus.alu_b[N-1]) &&
                       (bus.alu_c[N-1] != bus.alu_a[N-1]);
        end
      end
      2'b01: begin
        bus.alu_c  = bus.alu_a & bus.alu_b;
        bus.alu_ov = force_ov;
      end
      2'b10: begin
        bus.alu_c  = bus.alu_a | bus.alu_b;
        bus.alu_ov = force_ov;
      end
      default: begin
        bus.alu_c  = ~(bus.alu_a | bus.alu_b);
        bus.alu_ov = force_ov;
      end
    endcase
  end

  function automatic logic [N-1:0] ref_res(
    input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    case (op)
      3'b000:         return a + b;
      3'b100:         return a - b;
      3'b001, 3'b101: return a & b;
      3'b010, 3'b110: return a | b;
      default:        return ~(a | b);
    endcase
  endfunction

  // qualified overflow: true signed result outside the N-bit range
  function automatic bit ref_ov(
    input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    longint s;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (N - 1)) - 1;
    lo = -(longint'(1) <<< (N - 1));
    if (op == 3'b000)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 3'b100) s = longint'($signed(a)) - longint'($signed(b));
    else                   return 1'b0;
    return (s > hi) || (s < lo);
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return N'($urandom_range(0, 20));
      default: return N'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input string tag,
                         input logic [AW-1:0] a, input logic [N-1:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [N-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
    mdl[a]  = d;
  endtask

  task automatic run(input logic [2:0] op, input logic [AW-1:0] rd,
                     input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                     input bit hold, input bit ld_cap, input bit ld_same,
                     input logic [AW-1:0] la, input logic [N-1:0] ld);
    logic [N-1:0] ea;
    logic [N-1:0] eb;
    logic [N-1:0] er;
    bit           eov;
    chk("rdy_idle", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_instr = {op, rd, rs1, rs2};
    if (ld_same) begin
      ld_en   = 1'b1;
      ld_addr = la;
      ld_data = ld;
      mdl[la] = ld;
    end
    ea  = mdl[rs1];
    eb  = mdl[rs2];
    er  = ref_res(op, ea, eb);
    eov = ref_ov(op, ea, eb);
    tick();
    ld_en = 1'b0;
    if (!hold) bus.in_valid = 1'b0;
    chk("rdy_issue", bus.in_ready, 1'b0);
    chk("done_issue", bus.done, 1'b0);
    tick();
    chk("rdy_cap", bus.in_ready, 1'b0);
    chk("done_cap", bus.done, 1'b0);
    chk("alu_a", bus.alu_a, ea);
    chk("alu_b", bus.alu_b, eb);
    chk("alu_op", bus.alu_op, op);
    if (ld_cap) begin
      ld_en   = 1'b1;
      ld_addr = 3'd5;
      ld_data = 32'hAA;
    end
    tick();
    ld_en = 1'b0;
    chk("done_wb", bus.done, 1'b1);
    chk("done_rd", bus.done_rd, rd);
    chk("done_ov", bus.done_ov, eov);
    chk("rdy_wb", bus.in_ready, 1'b0);
    dbg_chk("dbg_prewrite", rd, mdl[rd]);
`ifdef OV_TRAP_EN
    if (!eov) mdl[rd] = er;
    if (eov)  trap_exp = 1'b1;
`else
    mdl[rd] = er;
`endif
    tick();
    chk("done_after", bus.done, 1'b0);
    chk("alu_a_hold", bus.alu_a, ea);
    dbg_chk("dbg_post", rd, mdl[rd]);
`ifdef OV_TRAP_EN
    chk("trap", trap, trap_exp);
`endif
    if (hold) begin
      chk("rdy_back", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
      tick();
      chk("no_reaccept", bus.in_ready, 1'b1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lops [6];
    logic [N-1:0] ltab [6];
    lops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    ltab = '{32'h00F0_F000, 32'hFFF0_FFF0, 32'h000F_000F,
             32'h00F0_F000, 32'hFFF0_FFF0, 32'h000F_000F};
    rst          = 1'b1;
    ld_en        = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
    dbg_addr     = '0;
    force_ov     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    for (int i = 0; i < REGS; i++) mdl[i] = '0;
`ifdef OV_TRAP_EN
    trap_exp = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_done_rd", bus.done_rd, '0);
    chk("rst_done_ov", bus.done_ov, 1'b0);
    chk("rst_alu_a", bus.alu_a, '0);
    chk("rst_alu_b", bus.alu_b, '0);
    chk("rst_alu_op", bus.alu_op, 3'b000);
`ifdef OV_TRAP_EN
    chk("rst_trap", trap, 1'b0);
`endif
    for (int i = 0; i < REGS; i++) dbg_chk("rst_reg", AW'(i), '0);

    preload(3'd1, 32'd5);
    preload(3'd2, 32'd3);
    run(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, '0, '0);
    dbg_chk("add_r3", 3'd3, 32'd8);

    preload(3'd1, 32'h7FFF_FFFF);
    preload(3'd2, 32'd1);
    run(3'b000, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, '0, '0);
`ifdef OV_TRAP_EN
    dbg_chk("ovf_r4", 3'd4, 32'h0);
    chk("ovf_trap", trap, 1'b1);
`else
    dbg_chk("ovf_r4", 3'd4, 32'h8000_0000);
`endif

    preload(3'd1, 32'hF0F0_F0F0);
    preload(3'd2, 32'h0FF0_FF00);
    force_ov = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run(lops[i], 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, '0, '0);
      dbg_chk("logic_tab", 3'd3, ltab[i]);
    end
    force_ov = 1'b0;

    preload(3'd1, 32'd10);
    preload(3'd2, 32'd3);
    run(3'b100, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, '0, '0);
    dbg_chk("sub_r1", 3'd1, 32'd7);

    preload(3'd5, 32'h1234);
    run(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, '0, '0);
    dbg_chk("ld_ignored_r5", 3'd5, 32'h1234);

    run(3'b000, 3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 32'd9);
    dbg_chk("ld_same_r6", 3'd6, 32'd18);

    // reset in CAPTURE of an ADD to r7
    bus.in_valid = 1'b1;
    bus.in_instr = {3'b000, 3'd7, 3'd1, 3'd2};
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < REGS; i++) mdl[i] = '0;
`ifdef OV_TRAP_EN
    trap_exp = 1'b0;
    chk("mid_rst_trap", trap, 1'b0);
`endif
    chk("mid_rst_ready", bus.in_ready, 1'b1);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_alu_a", bus.alu_a, '0);
    chk("mid_rst_alu_b", bus.alu_b, '0);
    chk("mid_rst_alu_op", bus.alu_op, 3'b000);
    dbg_chk("mid_rst_r7", 3'd7, '0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_done_after_rst", bus.done, 1'b0);
    end
    dbg_chk("r7_after_rst", 3'd7, '0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) preload(AW'($urandom), pick());
      if ($urandom_range(0, 1) == 1) preload(AW'($urandom), pick());
      force_ov = 1'($urandom);
      run(3'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
          1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
          AW'($urandom), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the 3-bit-opcode ALU interface. It accepts encoded register-to-register instructions over a valid/ready handshake and reads operands from an internal register file. It drives A/B/OP to an external combinational ALU, captures C/OV, writes the result back and reports completion. It sits between the instruction source and the ALU datapath in the CPU.

Parameters:
N, 32, data width of registers and ALU operands/result
REGS, 8, number of registers in the internal register file; power of two, at least 2
AW, 3, register address width; must equal log2(REGS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction present on in_instr
in_ready  output  1  controller can accept an instruction (high only in IDLE)
in_instr  input  3+3*AW  {op[2:0], rd, rs1, rs2}, op in the MSBs
ld_en  input  1  register preload strobe
ld_addr  input  AW  preload address
ld_data  input  N  preload data
alu_a  output  N  operand A to ALU
alu_b  output  N  operand B to ALU
alu_op  output  3  opcode to ALU
alu_c  input  N  ALU result
alu_ov  input  1  ALU overflow
done  output  1  one-cycle pulse at writeback
done_rd  output  AW  destination register of the completed instruction
done_ov  output  1  qualified overflow of the completed instruction
dbg_addr  input  AW  debug read address
dbg_data  output  N  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all registers = 0; alu_a=alu_b=0; alu_op=3'b000; done=0; done_rd=0; done_ov=0; in_ready=1 after reset release. Reset mid-instruction abandons it with no writeback and no done.
- Opcode map, same as the ALU: 000 ADD, 001 AND, 010 OR, 011 NOR, 100 SUB, 101 AND, 110 OR, 111 NOR.
- FSM states: IDLE, ISSUE, CAPTURE, WB.
  - IDLE: in_ready=1. When in_valid, latch the instruction and go to ISSUE.
  - ISSUE: alu_a=reg[rs1], alu_b=reg[rs2], alu_op=op, all registered. Go to CAPTURE.
  - CAPTURE: ALU outputs are stable. Sample alu_c and alu_ov into internal registers. Go to WB.
  - WB: reg[rd] <= captured C; done=1; done_rd=rd; done_ov = captured OV AND (op==000 or op==100). Go to IDLE.
- alu_a/alu_b/alu_op hold their last values in every state except ISSUE.
- OV from logical ops (001,010,011,101,110,111) is masked to 0 in done_ov.
- Latency: handshake at edge k; done high during cycle k+3. Maximum throughput is one instruction per 4 cycles. in_ready=0 in ISSUE, CAPTURE and WB.
- rd may equal rs1 or rs2: operands are read in ISSUE, before WB, so the old values are used.
- Preload:
  - ld_en is honoured only while the state is IDLE; it is ignored in other states.
  - ld_en and in_valid in the same IDLE cycle: the load is written at that edge, so ISSUE reads the loaded value.
- dbg_data is purely combinational. During WB it shows the pre-write value; the new value appears from the next cycle.
- Arithmetic is performed entirely by the external ALU. The controller does no width extension: C is N bits and is written verbatim.

Optional Feature:
OV_TRAP_EN
- Defined: when the qualified overflow is 1, WB does not write reg[rd]. done still pulses with done_ov=1. A sticky output trap (1 bit, reset 0) is set at that edge and stays set until rst.
- Not defined: the trap port is absent and overflowed results are written like any other.

Test Plan:
- Reset then preload reg1=5, reg2=3; issue ADD rd=3,rs1=1,rs2=2 -> done pulses exactly 3 cycles after the handshake, done_rd=3, dbg reg3=8, done_ov=0.
- Preload reg1=0x7FFFFFFF, reg2=1; ADD rd=4 -> done_ov=1 and reg4=0x80000000. With OV_TRAP_EN: reg4 stays 0 and trap=1.
- Preload reg1=0xF0F0F0F0, reg2=0x0FF0FF00; cycle ops 001/010/011/101/110/111 -> results 0x00F0F000, 0xFFF0FFF0, 0x000F000F, 0x00F0F000, 0xFFF0FFF0, 0x000F000F; done_ov=0 for all, even if the ALU model forces alu_ov=1.
- SUB with rd=rs1=1 (reg1=10) and rs2=2 (reg2=3) -> reg1=7. Hold in_valid high through the operation -> in_ready=0 for 3 cycles and no second accept until IDLE.
- Assert ld_en to reg5=0xAA during CAPTURE -> ignored, reg5 unchanged. Assert ld_en reg1=9 and in_valid ADD rd=6,rs1=1,rs2=1 in the same IDLE cycle -> reg6=18.
- Assert rst in CAPTURE of an ADD to rd=7 -> outputs return to reset values immediately, reg7=0, and no done pulse.
